// File: rtl/vdg_cfg_seq_if.sv
// Bus bundle for the VDG configuration sequencer: CPU write data in, latch outputs out.
// Each U8_clock rising edge carries exactly one CPU write on din. There is no valid/ready pair.
interface vdg_cfg_seq_if;
  logic [7:0] din;
  logic [5:0] mode;
  logic       ext_active;
  logic [7:0] ext_reg0;
  logic [7:0] ext_reg1;
  logic [7:0] ext_reg2;
  logic [7:0] ext_reg3;
  logic [2:0] state;

  modport master (
    output din,
    input  mode, ext_active, ext_reg0, ext_reg1, ext_reg2, ext_reg3, state
  );

  modport slave (
    input  din,
    output mode, ext_active, ext_reg0, ext_reg1, ext_reg2, ext_reg3, state
  );
endinterface

// File: rtl/vdg_cfg_seq.sv
// VDG mode latch with a three-byte unlock sequence that opens four extended config registers.
// Writes outside the extended states keep updating the legacy mode latch, key bytes included.
module vdg_cfg_seq #(
  parameter logic [7:0] KEY_A = 8'hA5,
  parameter logic [7:0] KEY_B = 8'h5A,
  parameter logic [7:0] KEY_C = 8'hC3
) (
  input  logic          U8_clock,
  input  logic          RESET,
  vdg_cfg_seq_if.slave  cfg_bus
);

  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    KEY1     = 3'd1,
    KEY2     = 3'd2,
    EXT_IDX  = 3'd3,
    EXT_DATA = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] mode_q, mode_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] ext_reg_q [4];
  logic [7:0] ext_reg_d [4];

  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) begin
      state_q <= NORMAL;
      mode_q  <= 6'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 4; i++) ext_reg_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) ext_reg_q[i] <= ext_reg_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ext_reg_d = ext_reg_q;
    case (state_q)
      NORMAL: begin
        mode_d = cfg_bus.din[7:2];
        if (cfg_bus.din == KEY_A) state_d = KEY1;
      end
      KEY1: begin
        mode_d = cfg_bus.din[7:2];
        if (cfg_bus.din == KEY_B)      state_d = KEY2;
        else if (cfg_bus.din == KEY_A) state_d = KEY1;
        else                           state_d = NORMAL;
      end
      KEY2: begin
        mode_d = cfg_bus.din[7:2];
        if (cfg_bus.din == KEY_C)      state_d = EXT_IDX;
        else if (cfg_bus.din == KEY_A) state_d = KEY1;
        else                           state_d = NORMAL;
      end
      EXT_IDX: begin
        // Bit 7 set on an index byte relocks; bits 6 and 3:2 are don't-care.
        if (cfg_bus.din[7]) begin
          state_d = NORMAL;
        end else begin
          idx_d   = cfg_bus.din[1:0];
          cnt_d   = cfg_bus.din[5:4];
          state_d = EXT_DATA;
        end
      end
      EXT_DATA: begin
        ext_reg_d[idx_q] = cfg_bus.din;
        idx_d            = idx_q + 2'd1;
        if (cnt_q == 2'd0) state_d = EXT_IDX;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign cfg_bus.state      = state_q;
  assign cfg_bus.mode       = mode_q;
  assign cfg_bus.ext_active = (state_q == EXT_IDX) || (state_q == EXT_DATA);
  assign cfg_bus.ext_reg0   = ext_reg_q[0];
  assign cfg_bus.ext_reg1   = ext_reg_q[1];
  assign cfg_bus.ext_reg2   = ext_reg_q[2];
  assign cfg_bus.ext_reg3   = ext_reg_q[3];

endmodule

// File: tb/tb_vdg_cfg_seq.sv
// Directed bench for vdg_cfg_seq: drivers push hand-computed expectations, a monitor pops and compares.
module tb_vdg_cfg_seq;
  logic U8_clock;
  logic RESET;

  vdg_cfg_seq_if bus ();

  vdg_cfg_seq #(
    .KEY_A(8'hA5),
    .KEY_B(8'h5A),
    .KEY_C(8'hC3)
  ) dut (
    .U8_clock (U8_clock),
    .RESET    (RESET),
    .cfg_bus  (bus.slave)
  );

  // Packed as {state[2:0], mode[5:0], ext_active, reg3, reg2, reg1, reg0}
  localparam int W = 42;
  logic [W-1:0] exp_q [$];
  string        name_q [$];
  int           checks = 0;
  int           errors = 0;
  event         sample_ev;

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [5:0] md,
                                        input logic act, input logic [31:0] regs);
    return {st, md, act, regs};
  endfunction

  // Clock/reset block: the clock is a write strobe, pulsed once per write.
  initial begin
    U8_clock = 1'b0;
    RESET    = 1'b1;
    bus.din  = 8'h00;
  end

  task automatic wr(input logic [7:0] d, input logic [2:0] st, input logic [5:0] md,
                    input logic act, input logic [31:0] regs, input string nm);
    bus.din = d;
    exp_q.push_back(pack(st, md, act, regs));
    name_q.push_back(nm);
    #5 U8_clock = 1'b1;
    #4 -> sample_ev;
    #1 U8_clock = 1'b0;
  endtask

  task automatic set_reset(input logic r, input string nm);
    RESET = r;
    #2;
    if (r) begin
      exp_q.push_back('0);
      name_q.push_back(nm);
      -> sample_ev;
      #1;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] act_v, exp_v;
    string nm;
    forever begin
      @(sample_ev);
      act_v = {bus.state, bus.mode, bus.ext_active,
               bus.ext_reg3, bus.ext_reg2, bus.ext_reg1, bus.ext_reg0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got state=%0d mode=%h act=%b regs=%h, required no sample",
                 act_v[41:39], act_v[38:33], act_v[32], act_v[31:0]);
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got state=%0d mode=%h act=%b regs(3..0)=%h, required state=%0d mode=%h act=%b regs(3..0)=%h",
                   nm, act_v[41:39], act_v[38:33], act_v[32], act_v[31:0],
                   exp_v[41:39], exp_v[38:33], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // Driver: directed vectors
  initial begin
    #1;
    set_reset(1'b1, "reset_initial");
    set_reset(1'b0, "");

    // Unlock
    wr(8'hA5, 3'd1, 6'h29, 1'b0, 32'h00000000, "unlock_a");
    wr(8'h5A, 3'd2, 6'h16, 1'b0, 32'h00000000, "unlock_b");
    wr(8'hC3, 3'd3, 6'h30, 1'b1, 32'h00000000, "unlock_c");

    // Burst of 4 from idx 2 with wrap
    wr(8'h32, 3'd4, 6'h30, 1'b1, 32'h00000000, "idx_32");
    wr(8'h11, 3'd4, 6'h30, 1'b1, 32'h00110000, "burst_d0");
    wr(8'h22, 3'd4, 6'h30, 1'b1, 32'h22110000, "burst_d1");
    wr(8'h33, 3'd4, 6'h30, 1'b1, 32'h22110033, "burst_d2_wrap");
    wr(8'h44, 3'd3, 6'h30, 1'b1, 32'h22114433, "burst_d3_end");

    // Lock, then legacy write
    wr(8'h80, 3'd0, 6'h30, 1'b0, 32'h22114433, "lock");
    wr(8'h20, 3'd0, 6'h08, 1'b0, 32'h22114433, "legacy_20");

    // Partial keys
    wr(8'hA5, 3'd1, 6'h29, 1'b0, 32'h22114433, "key_a1");
    wr(8'hA5, 3'd1, 6'h29, 1'b0, 32'h22114433, "key_a_again");
    wr(8'h5A, 3'd2, 6'h16, 1'b0, 32'h22114433, "key_b");
    wr(8'h00, 3'd0, 6'h00, 1'b0, 32'h22114433, "key_abort");

    // KEY2 seeing KEY_A restarts at KEY1, then full unlock
    wr(8'hA5, 3'd1, 6'h29, 1'b0, 32'h22114433, "re_a");
    wr(8'h5A, 3'd2, 6'h16, 1'b0, 32'h22114433, "re_b");
    wr(8'hA5, 3'd1, 6'h29, 1'b0, 32'h22114433, "key2_a_restart");
    wr(8'h5A, 3'd2, 6'h16, 1'b0, 32'h22114433, "re_b2");
    wr(8'hC3, 3'd3, 6'h30, 1'b1, 32'h22114433, "re_c");

    // Index byte with don't-care bits set; bit 7 of data does not lock
    wr(8'h4F, 3'd4, 6'h30, 1'b1, 32'h22114433, "idx_4f_ignored_bits");
    wr(8'h80, 3'd3, 6'h30, 1'b1, 32'h80114433, "data_80_no_lock");

    // Mid-burst reset
    wr(8'h10, 3'd4, 6'h30, 1'b1, 32'h80114433, "idx_10");
    wr(8'hFF, 3'd4, 6'h30, 1'b1, 32'h801144FF, "burst_ff");
    set_reset(1'b1, "reset_mid_burst");
    wr(8'hC3, 3'd0, 6'h00, 1'b0, 32'h00000000, "edge_during_reset");
    set_reset(1'b0, "");
    wr(8'hC3, 3'd0, 6'h30, 1'b0, 32'h00000000, "post_reset_c_only");

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/vdg_cfg_seq.md
VDG_CFG_SEQ -- requirements
Module: vdg_cfg_seq

Interface
REQ-001 SHALL have parameter KEY_A, default 8'hA5, meaning the first unlock byte.
REQ-002 SHALL have parameter KEY_B, default 8'h5A, meaning the second unlock byte.
REQ-003 SHALL have parameter KEY_C, default 8'hC3, meaning the third unlock byte.
REQ-004 SHALL have port U8_clock  input  1  video-latch write strobe; each rising edge is exactly one CPU write, with no free-running clock.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port din  input  8  CPU write data, stable at the U8_clock rising edge.
REQ-007 SHALL have port mode  output  6  legacy VDG mode latch, equal to din[7:2] of the last accepted legacy write.
REQ-008 SHALL have port ext_active  output  1  high while the state is EXT_IDX or EXT_DATA.
REQ-009 SHALL have ports ext_reg0..ext_reg3  output  8 each  extended configuration registers.
REQ-010 SHALL have port state  output  3  encoded FSM state for debug: NORMAL=0, KEY1=1, KEY2=2, EXT_IDX=3, EXT_DATA=4.

Function
REQ-011 SHALL update all registers only on the U8_clock rising edge or on RESET.
REQ-012 SHALL implement the states NORMAL, KEY1, KEY2, EXT_IDX and EXT_DATA.
REQ-013 In NORMAL, KEY1 and KEY2, every write SHALL load mode<=din[7:2], including key bytes, for legacy compatibility.
REQ-014 In EXT_IDX and EXT_DATA, mode SHALL hold its value.
REQ-015 Key transitions SHALL be:
- NORMAL: din==KEY_A -> KEY1, else stay in NORMAL.
- KEY1: din==KEY_B -> KEY2; din==KEY_A -> KEY1; else -> NORMAL.
- KEY2: din==KEY_C -> EXT_IDX; din==KEY_A -> KEY1; else -> NORMAL.
REQ-016 In EXT_IDX, a write with din[7]=1 SHALL return the FSM to NORMAL, leaving ext_reg0..3 unchanged (lock).
REQ-017 In EXT_IDX, a write with din[7]=0 SHALL load idx<=din[1:0] and cnt<=din[5:4], then move to EXT_DATA; din[6] and din[3:2] are ignored.
REQ-018 In EXT_DATA, each write SHALL:
- load ext_reg[idx]<=din (full 8 bits);
- set idx<=idx+1 modulo 4 (3 wraps to 0);
- if cnt==0, go to EXT_IDX; else set cnt<=cnt-1 and stay in EXT_DATA.
REQ-019 Burst length SHALL therefore be cnt+1, i.e. 1..4 data writes per index byte.
REQ-020 In EXT_DATA, din[7] SHALL be treated as data and SHALL NOT cause a lock.
REQ-021 Only one ext_reg SHALL change per write, with no read-back path.
REQ-022 ext_reg0..3, mode, ext_active and state SHALL be registered outputs with zero combinational path from din.
REQ-023 ext_active SHALL be decoded from the registered state: 1 in states 3 and 4, else 0.
REQ-024 Illegal state encodings 5-7 SHALL move to NORMAL on the next edge without modifying mode or ext_reg.

Reset
REQ-025 Asserting RESET SHALL immediately, without an edge, force:
- state=NORMAL;
- mode=6'd0;
- ext_reg0..3=8'h00;
- idx=0, cnt=0;
- ext_active=0.
REQ-026 RESET mid-burst or mid-key SHALL abandon the sequence; the next unlock requires the full KEY_A, KEY_B, KEY_C sequence.
REQ-027 While RESET is high, U8_clock edges SHALL have no effect.

Verification
REQ-028 Writes 8'hA5, 8'h5A, 8'hC3 -> state=3, ext_active=1, mode=6'h30 (din[7:2] of 8'hC3).
REQ-029 From EXT_IDX, write 8'h32 (idx=2, cnt=3), then 11,22,33,44 -> ext_reg2=11, ext_reg3=22, ext_reg0=33, ext_reg1=44, state=3; mode is unchanged throughout.
REQ-030 Writes A5, A5, 5A, 00 -> states 1, 1, 2, 0; mode=0; ext_active stays 0.
REQ-031 From EXT_IDX, write 8'h80 -> state=0, registers retained; the next write 8'h20 gives mode=6'h08.
REQ-032 Unlock, write 8'h10 (idx=0, cnt=1), write 8'hFF, then assert RESET -> all outputs=0, ext_reg0=0, state=0; after release, write 8'hC3 -> state stays 0.
REQ-033 In EXT_DATA, write 8'h80 -> it is stored as data in ext_reg[idx] and the FSM does not lock.
